custom_bus_initiator: RTL and testbench
=======================================

Name: custom_bus_initiator

Overview:
Initiator (master) side of the strobe/ack word interface that custom logic blocks present behind the AMBA slave bridge. It accepts commands from a local controller and drives single-word or incrementing-burst reads and writes into a custom block, one beat at a time. It returns read data or a timeout error per beat. It serves as an on-chip DMA/self-test engine and as the stimulus driver for custom blocks.

Parameters:
TIMEOUT, 16, cycles strobe may stay high without ack before the beat is aborted (1..255)
LEN_W, 4, width of burst-length field; a burst is at most 2^LEN_W beats

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  initiator can accept a command
cmd_we  in  1  1 = write, 0 = read
cmd_adr  in  32  byte start address; bits [1:0] ignored
cmd_wdata  in  32  write data, used for every beat of a write burst (fill)
cmd_len  in  LEN_W  number of beats minus 1
strobe  out  1  bus request
we  out  1  bus write enable
adr  out  32  bus word address
data_out  out  32  write data to slave
data_in  in  32  read data from slave
ack  in  1  slave acknowledge; may be high in the same cycle as strobe
rsp_valid  out  1  beat response present
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  32  read data (0 for writes and errors)
rsp_err  out  1  beat timed out
rsp_last  out  1  final response of the command

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset is asynchronous: strobe drops immediately. Any in-flight command is discarded with no response.
- States: IDLE, REQ, RSP.
- IDLE: cmd_ready=1, all other outputs 0.
  - On a clk edge with cmd_valid=1: latch we, adr = {cmd_adr[31:2],2'b00}, wdata and len; beat counter=0; go to REQ.
  - strobe rises in the cycle after acceptance.
- REQ: strobe=1. we, adr and data_out are stable for the whole state. cmd_ready=0.
  - Edge with ack=1: capture data_in when we=0 (0 when we=1); rsp_err=0; rsp_last = (beat==len); go to RSP.
  - Timeout: a counter starts at 0 on entry and increments each edge with ack=0. If it reaches TIMEOUT-1 with ack=0, the next edge goes to RSP with rsp_err=1, rsp_rdata=0, rsp_last=1. The remaining beats are abandoned.
  - ack high on the same edge the counter expires: treated as success.
- RSP: strobe=0. rsp_valid=1 and all rsp_* fields stay stable until rsp_ready.
  - Edge with rsp_ready=1: if rsp_last, go to IDLE. Otherwise beat+1, adr+4, go to REQ.
  - adr wraps modulo 2^32: 0xFFFFFFFC + 4 = 0x00000000.
- ack while strobe=0 is ignored.
- Minimum beat period is 2 cycles (REQ, RSP), so strobe is low for at least one cycle between beats.
- Latency with ack in the strobe cycle and rsp_ready held high:
  - command accepted at edge 0
  - strobe high in cycle 1
  - rsp_valid high in cycle 2
  - next beat strobe in cycle 3
- Single outstanding command. cmd_ready=0 from acceptance until the edge that leaves RSP with rsp_last.

Test Plan:
- Single write: cmd we=1 adr=0xA0160000 wdata=0x00000003 len=0, ack tied to strobe -> strobe high exactly 1 cycle with adr=0xA0160000 data_out=3 we=1; rsp_valid next cycle, err=0, last=1, rdata=0.
- Read burst: we=0 adr=0xA0160010 len=3, slave returns adr low byte as data -> bus adr 0x10,0x14,0x18,0x1C in order; rsp_rdata 0x10,0x14,0x18,0x1C; last only on the 4th beat.
- Back-pressure: rsp_ready low 5 cycles on beat 0 of a 2-beat read -> rsp fields held stable, strobe stays low, beat 1 strobe starts the cycle after rsp_ready rises.
- Timeout: TIMEOUT=16, ack never asserts on beat 1 of a 3-beat read -> strobe high exactly 16 cycles, then rsp err=1 last=1 rdata=0; no beat 2 issued; cmd_ready high after handshake.
- Delayed ack and wrap: ack 3 cycles after strobe, adr=0xFFFFFFFC len=1 -> strobe high 4 cycles per beat; second beat adr=0x00000000.
- Reset mid-burst: rst_n low during REQ of beat 2 -> strobe, rsp_valid and cmd_ready 0 asynchronously; after release, cmd_ready=1 and a new single read completes normally.

Source files
------------

// File: rtl/custom_bus_initiator_if.sv
// ---------------------------------------------------------------------------
// custom_bus_initiator_if
//   Bundles the three channels around the strobe/ack initiator:
//     command  : cmd_valid/cmd_ready handshake with we, start address,
//                fill data and burst length (beats minus 1)
//     bus      : strobe/we/adr/data_out toward the custom block,
//                data_in/ack back from it
//     response : rsp_valid/rsp_ready handshake with per-beat read data,
//                timeout error flag and last-beat marker
//   modport master : view of the initiator
//   modport slave  : view of everything around it (controller, custom block,
//                    response consumer)
// ---------------------------------------------------------------------------
interface custom_bus_initiator_if #(
    parameter int LEN_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_we;
    logic [31:0]      cmd_adr;
    logic [31:0]      cmd_wdata;
    logic [LEN_W-1:0] cmd_len;

    logic             strobe;
    logic             we;
    logic [31:0]      adr;
    logic [31:0]      data_out;
    logic [31:0]      data_in;
    logic             ack;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_rdata;
    logic             rsp_err;
    logic             rsp_last;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_wdata, cmd_len,
        output cmd_ready,
        output strobe, we, adr, data_out,
        input  data_in, ack,
        output rsp_valid, rsp_rdata, rsp_err, rsp_last,
        input  rsp_ready
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_wdata, cmd_len,
        input  cmd_ready,
        input  strobe, we, adr, data_out,
        output data_in, ack,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_last,
        output rsp_ready
    );
endinterface

// File: rtl/custom_bus_initiator.sv
// ---------------------------------------------------------------------------
// custom_bus_initiator
//   Initiator side of the strobe/ack word bus. Takes one command at a time
//   and runs it as single or incrementing-burst beats, one response per beat.
//   A beat that sees no ack for TIMEOUT strobe cycles is aborted with an
//   error response, which also ends the command.
//
//   Ports:
//     clk   : clock
//     rst_n : asynchronous active-low reset
//     bus   : custom_bus_initiator_if.master (command, bus, response channels)
//
//   States:
//     state | meaning
//     IDLE  | cmd_ready high, waiting for a command
//     REQ   | strobe high for the current beat, waiting for ack or timeout
//     RSP   | beat response presented, waiting for rsp_ready
// ---------------------------------------------------------------------------
module custom_bus_initiator #(
    parameter int TIMEOUT = 16,
    parameter int LEN_W   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    custom_bus_initiator_if.master bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RSP  = 2'd2;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]       state_q,     state_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             strobe_q,    strobe_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             we_q,        we_d;
    logic [31:0]      adr_q,       adr_d;
    logic [31:0]      wdata_q,     wdata_d;
    logic [LEN_W-1:0] len_q,       len_d;
    logic [LEN_W-1:0] beat_q,      beat_d;
    logic [7:0]       tmo_q,       tmo_d;
    logic [31:0]      rdata_q,     rdata_d;
    logic             err_q,       err_d;
    logic             last_q,      last_d;

    // Word addressing: the byte-lane bits of the start address carry no meaning.
    logic unused_adr_lsb;
    assign unused_adr_lsb = ^bus.cmd_adr[1:0];

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        strobe_d    = strobe_q;
        rsp_valid_d = rsp_valid_q;
        we_d        = we_q;
        adr_d       = adr_q;
        wdata_d     = wdata_q;
        len_d       = len_q;
        beat_d      = beat_q;
        tmo_d       = tmo_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        last_d      = last_q;

        case (state_q)
            ST_IDLE: begin
                // cmd_ready_q is still low on the first cycle after reset
                // release; gating on it keeps the handshake honest.
                cmd_ready_d = 1'b1;
                if (bus.cmd_valid && cmd_ready_q) begin
                    we_d        = bus.cmd_we;
                    adr_d       = {bus.cmd_adr[31:2], 2'b00};
                    wdata_d     = bus.cmd_wdata;
                    len_d       = bus.cmd_len;
                    beat_d      = '0;
                    tmo_d       = 8'd0;
                    cmd_ready_d = 1'b0;
                    strobe_d    = 1'b1;
                    state_d     = ST_REQ;
                end
            end

            ST_REQ: begin
                // ack wins over a timeout expiring on the same edge.
                if (bus.ack) begin
                    rdata_d     = we_q ? 32'h0 : bus.data_in;
                    err_d       = 1'b0;
                    last_d      = (beat_q == len_q);
                    strobe_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end else if (tmo_q == TMO_LAST) begin
                    // Abort: remaining beats of the burst are abandoned.
                    rdata_d     = 32'h0;
                    err_d       = 1'b1;
                    last_d      = 1'b1;
                    strobe_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end

            ST_RSP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rdata_d     = 32'h0;
                    err_d       = 1'b0;
                    last_d      = 1'b0;
                    if (last_q) begin
                        cmd_ready_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        beat_d   = beat_q + 1'b1;
                        adr_d    = adr_q + 32'd4;  // wraps modulo 2^32
                        tmo_d    = 8'd0;
                        strobe_d = 1'b1;
                        state_d  = ST_REQ;
                    end
                end
            end

            default: begin
                cmd_ready_d = 1'b0;
                strobe_d    = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            strobe_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= 32'h0;
            wdata_q     <= 32'h0;
            len_q       <= '0;
            beat_q      <= '0;
            tmo_q       <= 8'd0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            strobe_q    <= strobe_d;
            rsp_valid_q <= rsp_valid_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            wdata_q     <= wdata_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            tmo_q       <= tmo_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            last_q      <= last_d;
        end
    end

    // Bus qualifiers are forced to 0 outside a strobe so the block sees a
    // quiet bus while idle or while a response is pending.
    assign bus.cmd_ready = cmd_ready_q;
    assign bus.strobe    = strobe_q;
    assign bus.we        = strobe_q & we_q;
    assign bus.adr       = strobe_q ? adr_q : 32'h0;
    assign bus.data_out  = (strobe_q && we_q) ? wdata_q : 32'h0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.rsp_last  = last_q;

endmodule

// File: tb/tb_custom_bus_initiator.sv
module tb_custom_bus_initiator;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    custom_bus_initiator_if #(.LEN_W(4)) bus_if ();

    custom_bus_initiator #(
        .TIMEOUT(16),
        .LEN_W  (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    // Slave model: ack after ack_delay strobe cycles, data = low address byte,
    // optional refusal to ack one address.
    int          ack_delay;
    logic        block_en;
    logic [31:0] block_adr;
    logic [7:0]  strobe_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) strobe_cnt <= 8'd0;
        else        strobe_cnt <= bus_if.strobe ? strobe_cnt + 8'd1 : 8'd0;
    end

    assign bus_if.ack = bus_if.strobe && (int'(strobe_cnt) >= ack_delay)
                        && !(block_en && (bus_if.adr == block_adr));
    assign bus_if.data_in = {24'h0, bus_if.adr[7:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_cmd(input logic c_we, input logic [31:0] c_adr,
                            input logic [31:0] c_wdata, input logic [3:0] c_len);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_we    = c_we;
        bus_if.cmd_adr   = c_adr;
        bus_if.cmd_wdata = c_wdata;
        bus_if.cmd_len   = c_len;
        @(negedge clk);
        bus_if.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_if.strobe, bus_if.cmd_ready, bus_if.rsp_valid, bus_if.we} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctl: got strobe/cmd_ready/rsp_valid/we=%b want 0000",
                     {bus_if.strobe, bus_if.cmd_ready, bus_if.rsp_valid, bus_if.we});
        end
        checks++;
        if ({bus_if.adr, bus_if.data_out, bus_if.rsp_rdata, bus_if.rsp_err, bus_if.rsp_last} !== 98'h0) begin
            failures++;
            $display("FAIL reset_data: got adr=%h data_out=%h rdata=%h err=%b last=%b want all 0",
                     bus_if.adr, bus_if.data_out, bus_if.rsp_rdata, bus_if.rsp_err, bus_if.rsp_last);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_if.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b want 1", bus_if.cmd_ready);
        end
    endtask

    task automatic test_single_write();
        ack_delay = 0;
        bus_if.rsp_ready = 1'b1;
        send_cmd(1'b1, 32'hA016_0000, 32'h0000_0003, 4'd0);
        checks++;
        if ({bus_if.strobe, bus_if.we, bus_if.adr, bus_if.data_out, bus_if.cmd_ready, bus_if.rsp_valid}
            !== {1'b1, 1'b1, 32'hA016_0000, 32'h0000_0003, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL wr_strobe: got stb=%b we=%b adr=%h dout=%h rdy=%b rv=%b want 1 1 a0160000 00000003 0 0",
                     bus_if.strobe, bus_if.we, bus_if.adr, bus_if.data_out, bus_if.cmd_ready, bus_if.rsp_valid);
        end
        @(negedge clk);
        checks++;
        if ({bus_if.strobe, bus_if.rsp_valid, bus_if.rsp_err, bus_if.rsp_last, bus_if.rsp_rdata}
            !== {1'b0, 1'b1, 1'b0, 1'b1, 32'h0}) begin
            failures++;
            $display("FAIL wr_rsp: got stb=%b rv=%b err=%b last=%b rdata=%h want 0 1 0 1 00000000",
                     bus_if.strobe, bus_if.rsp_valid, bus_if.rsp_err, bus_if.rsp_last, bus_if.rsp_rdata);
        end
        @(negedge clk);
        checks++;
        if ({bus_if.strobe, bus_if.rsp_valid, bus_if.cmd_ready} !== 3'b001) begin
            failures++;
            $display("FAIL wr_done: got stb/rv/rdy=%b want 001",
                     {bus_if.strobe, bus_if.rsp_valid, bus_if.cmd_ready});
        end
    endtask

    task automatic test_read_burst();
        logic [31:0] exp_adr;
        ack_delay = 0;
        bus_if.rsp_ready = 1'b1;
        send_cmd(1'b0, 32'hA016_0010, 32'h0, 4'd3);
        for (int i = 0; i < 4; i++) begin
            exp_adr = 32'hA016_0010 + 32'(4 * i);
            checks++;
            if ({bus_if.strobe, bus_if.we, bus_if.adr} !== {1'b1, 1'b0, exp_adr}) begin
                failures++;
                $display("FAIL rd_beat%0d_bus: got stb=%b we=%b adr=%h want 1 0 %h",
                         i, bus_if.strobe, bus_if.we, bus_if.adr, exp_adr);
            end
            @(negedge clk);
            checks++;
            if ({bus_if.strobe, bus_if.rsp_valid, bus_if.rsp_err, bus_if.rsp_last, bus_if.rsp_rdata}
                !== {1'b0, 1'b1, 1'b0, (i == 3), {24'h0, exp_adr[7:0]}}) begin
                failures++;
                $display("FAIL rd_beat%0d_rsp: got stb=%b rv=%b err=%b last=%b rdata=%h want 0 1 0 %0d %h",
                         i, bus_if.strobe, bus_if.rsp_valid, bus_if.rsp_err, bus_if.rsp_last,
                         bus_if.rsp_rdata, (i == 3), {24'h0, exp_adr[7:0]});
            end
            @(negedge clk);
        end
        checks++;
        if ({bus_if.strobe, bus_if.cmd_ready} !== 2'b01) begin
            failures++;
            $display("FAIL rd_done: got stb/rdy=%b want 01", {bus_if.strobe, bus_if.cmd_ready});
        end
    endtask

    task automatic test_back_pressure();
        ack_delay = 0;
        bus_if.rsp_ready = 1'b0;
        send_cmd(1'b0, 32'hA016_0040, 32'h0, 4'd1);
        checks++;
        if ({bus_if.strobe, bus_if.adr} !== {1'b1, 32'hA016_0040}) begin
            failures++;
            $display("FAIL bp_beat0_bus: got stb=%b adr=%h want 1 a0160040", bus_if.strobe, bus_if.adr);
        end
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({bus_if.strobe, bus_if.rsp_valid, bus_if.rsp_err, bus_if.rsp_last, bus_if.rsp_rdata}
                !== {1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0040}) begin
                failures++;
                $display("FAIL bp_hold%0d: got stb=%b rv=%b err=%b last=%b rdata=%h want 0 1 0 0 00000040",
                         k, bus_if.strobe, bus_if.rsp_valid, bus_if.rsp_err, bus_if.rsp_last, bus_if.rsp_rdata);
            end
            if (k == 4) bus_if.rsp_ready = 1'b1;
            @(negedge clk);
        end
        checks++;
        if ({bus_if.strobe, bus_if.rsp_valid, bus_if.adr} !== {1'b1, 1'b0, 32'hA016_0044}) begin
            failures++;
            $display("FAIL bp_beat1_bus: got stb=%b rv=%b adr=%h want 1 0 a0160044",
                     bus_if.strobe, bus_if.rsp_valid, bus_if.adr);
        end
        @(negedge clk);
        checks++;
        if ({bus_if.rsp_valid, bus_if.rsp_last, bus_if.rsp_rdata} !== {1'b1, 1'b1, 32'h0000_0044}) begin
            failures++;
            $display("FAIL bp_beat1_rsp: got rv=%b last=%b rdata=%h want 1 1 00000044",
                     bus_if.rsp_valid, bus_if.rsp_last, bus_if.rsp_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int n;
        ack_delay = 0;
        block_en  = 1'b1;
        block_adr = 32'hA016_0084;
        bus_if.rsp_ready = 1'b1;
        send_cmd(1'b0, 32'hA016_0080, 32'h0, 4'd2);
        @(negedge clk);
        checks++;
        if ({bus_if.rsp_valid, bus_if.rsp_err, bus_if.rsp_last, bus_if.rsp_rdata}
            !== {1'b1, 1'b0, 1'b0, 32'h0000_0080}) begin
            failures++;
            $display("FAIL to_beat0_rsp: got rv=%b err=%b last=%b rdata=%h want 1 0 0 00000080",
                     bus_if.rsp_valid, bus_if.rsp_err, bus_if.rsp_last, bus_if.rsp_rdata);
        end
        @(negedge clk);
        n = 0;
        while (bus_if.strobe === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL to_strobe_len: got %0d cycles want 16", n);
        end
        checks++;
        if ({bus_if.rsp_valid, bus_if.rsp_err, bus_if.rsp_last, bus_if.rsp_rdata}
            !== {1'b1, 1'b1, 1'b1, 32'h0}) begin
            failures++;
            $display("FAIL to_rsp: got rv=%b err=%b last=%b rdata=%h want 1 1 1 00000000",
                     bus_if.rsp_valid, bus_if.rsp_err, bus_if.rsp_last, bus_if.rsp_rdata);
        end
        @(negedge clk);
        checks++;
        if ({bus_if.strobe, bus_if.rsp_valid, bus_if.cmd_ready} !== 3'b001) begin
            failures++;
            $display("FAIL to_done: got stb/rv/rdy=%b want 001",
                     {bus_if.strobe, bus_if.rsp_valid, bus_if.cmd_ready});
        end
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus_if.strobe === 1'b1) n++;
        end
        checks++;
        if (n != 0) begin
            failures++;
            $display("FAIL to_no_beat2: got %0d strobe cycles want 0", n);
        end
        block_en = 1'b0;
    endtask

    task automatic test_delayed_ack_wrap();
        int n;
        logic [31:0] exp_adr;
        ack_delay = 3;
        bus_if.rsp_ready = 1'b1;
        send_cmd(1'b0, 32'hFFFF_FFFC, 32'h0, 4'd1);
        for (int b = 0; b < 2; b++) begin
            exp_adr = (b == 0) ? 32'hFFFF_FFFC : 32'h0000_0000;
            n = 0;
            while (bus_if.strobe === 1'b1 && n < 40) begin
                if (bus_if.adr !== exp_adr) begin
                    checks++;
                    failures++;
                    $display("FAIL wrap_adr%0d: got %h want %h", b, bus_if.adr, exp_adr);
                end
                n++;
                @(negedge clk);
            end
            checks++;
            if (n != 4) begin
                failures++;
                $display("FAIL wrap_strobe_len%0d: got %0d cycles want 4", b, n);
            end
            checks++;
            if ({bus_if.rsp_valid, bus_if.rsp_err, bus_if.rsp_last, bus_if.rsp_rdata}
                !== {1'b1, 1'b0, (b == 1), {24'h0, exp_adr[7:0]}}) begin
                failures++;
                $display("FAIL wrap_rsp%0d: got rv=%b err=%b last=%b rdata=%h want 1 0 %0d %h",
                         b, bus_if.rsp_valid, bus_if.rsp_err, bus_if.rsp_last, bus_if.rsp_rdata,
                         (b == 1), {24'h0, exp_adr[7:0]});
            end
            @(negedge clk);
        end
        checks++;
        if (bus_if.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL wrap_done: got cmd_ready=%b want 1", bus_if.cmd_ready);
        end
    endtask

    task automatic test_reset_mid_burst();
        int n;
        ack_delay = 3;
        bus_if.rsp_ready = 1'b1;
        send_cmd(1'b0, 32'hA016_0100, 32'h0, 4'd3);
        n = 0;
        while (!(bus_if.strobe === 1'b1 && bus_if.adr === 32'hA016_0108) && n < 40) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n >= 40) begin
            failures++;
            $display("FAIL rst_reach_beat2: got no strobe at a0160108 within 40 cycles");
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus_if.strobe, bus_if.rsp_valid, bus_if.cmd_ready} !== 3'b000) begin
            failures++;
            $display("FAIL rst_async: got stb/rv/rdy=%b want 000",
                     {bus_if.strobe, bus_if.rsp_valid, bus_if.cmd_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        ack_delay = 0;
        @(negedge clk);
        checks++;
        if ({bus_if.strobe, bus_if.rsp_valid, bus_if.cmd_ready} !== 3'b001) begin
            failures++;
            $display("FAIL rst_after: got stb/rv/rdy=%b want 001",
                     {bus_if.strobe, bus_if.rsp_valid, bus_if.cmd_ready});
        end
        send_cmd(1'b0, 32'hA016_0237, 32'h0, 4'd0);
        checks++;
        if ({bus_if.strobe, bus_if.we, bus_if.adr} !== {1'b1, 1'b0, 32'hA016_0234}) begin
            failures++;
            $display("FAIL rst_new_bus: got stb=%b we=%b adr=%h want 1 0 a0160234",
                     bus_if.strobe, bus_if.we, bus_if.adr);
        end
        @(negedge clk);
        checks++;
        if ({bus_if.rsp_valid, bus_if.rsp_err, bus_if.rsp_last, bus_if.rsp_rdata}
            !== {1'b1, 1'b0, 1'b1, 32'h0000_0034}) begin
            failures++;
            $display("FAIL rst_new_rsp: got rv=%b err=%b last=%b rdata=%h want 1 0 1 00000034",
                     bus_if.rsp_valid, bus_if.rsp_err, bus_if.rsp_last, bus_if.rsp_rdata);
        end
        @(negedge clk);
        checks++;
        if (bus_if.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_new_done: got cmd_ready=%b want 1", bus_if.cmd_ready);
        end
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        rst_n            = 1'b0;
        ack_delay        = 0;
        block_en         = 1'b0;
        block_adr        = 32'h0;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_we    = 1'b0;
        bus_if.cmd_adr   = 32'h0;
        bus_if.cmd_wdata = 32'h0;
        bus_if.cmd_len   = 4'd0;
        bus_if.rsp_ready = 1'b0;

        test_reset();
        test_single_write();
        test_read_burst();
        test_back_pressure();
        test_timeout();
        test_delayed_ack_wrap();
        test_reset_mid_burst();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
